// File: rtl/subservient_timer_pkg.sv
// Shared definitions for the subservient machine timer: register map,
// CTRL bit positions, reset constants and the byte-lane merge helper.
package subservient_timer_pkg;

   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_CTRL        = 3'd4,
      REG_STATUS      = 3'd5,
      REG_RSVD6       = 3'd6,
      REG_RSVD7       = 3'd7
   } reg_off_e;

   localparam int unsigned CTRL_EN = 0;
   localparam int unsigned CTRL_IE = 1;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Byte lanes with sel set take new_val, the rest keep old_val.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/subservient_timer_if.sv
// Wishbone classic bus between the CPU wrapper's external data port and the timer.
interface subservient_timer_if;
   // Handshake: the master raises i_wb_stb with adr/dat/sel/we stable and holds
   // it until o_wb_ack; ack is a single-cycle pulse and o_wb_rdt is only
   // meaningful while ack is high.
   logic [31:0] i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we;
   logic        i_wb_stb;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;

   modport master (
      output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
      input  o_wb_rdt, o_wb_ack
   );

   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
      output o_wb_rdt, o_wb_ack
   );
endinterface

// File: rtl/subservient_timer.sv
// RISC-V machine timer on the subservient external Wishbone bus: 64-bit mtime
// with prescaler, mtimecmp, coherent LO/HI reads through a shadow, level irq.
module subservient_timer
   import subservient_timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
)
(
   input  logic               i_clk,
   input  logic               i_rst,
   subservient_timer_if.slave wb,
   output logic               o_timer_irq
);

   localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

   logic        ack_q, ack_d;
   logic [31:0] rdt_q, rdt_d;
   logic [31:0] mtime_lo_q, mtime_lo_d;
   logic [31:0] mtime_hi_q, mtime_hi_d;
   logic [31:0] cmp_lo_q, cmp_lo_d;
   logic [31:0] cmp_hi_q, cmp_hi_d;
   logic [31:0] shadow_q, shadow_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic [15:0] presc_q, presc_d;
   logic        irq_q, irq_d;

   reg_off_e    off;
   logic        req, wr, rd;
   logic        tick, carry, cmp_hit;
   logic [31:0] ctrl_word, ctrl_new;
   logic        unused_bits;

   assign off       = reg_off_e'(wb.i_wb_adr[4:2]);
   assign req       = wb.i_wb_stb & ~ack_q;
   assign wr        = req & wb.i_wb_we;
   assign rd        = req & ~wb.i_wb_we;
   assign tick      = en_q & (presc_q == PRESCALE_MAX);
   assign carry     = tick & (&mtime_lo_q);
   assign cmp_hit   = {mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q};
   assign ctrl_word = {30'd0, ie_q, en_q};
   assign ctrl_new  = byte_merge(ctrl_word, wb.i_wb_dat, wb.i_wb_sel);

   assign unused_bits = ^{wb.i_wb_adr[31:5], wb.i_wb_adr[1:0], ctrl_new[31:2]};

   always_comb begin
      ack_d      = req;
      presc_d    = presc_q;
      mtime_lo_d = mtime_lo_q + {31'd0, tick};
      mtime_hi_d = mtime_hi_q + {31'd0, carry};
      cmp_lo_d   = cmp_lo_q;
      cmp_hi_d   = cmp_hi_q;
      shadow_d   = shadow_q;
      en_d       = en_q;
      ie_d       = ie_q;
      rdt_d      = '0;
      irq_d      = ie_q & cmp_hit;

      if (en_q) presc_d = tick ? 16'd0 : presc_q + 16'd1;

      // Shadow captures the high word in the same edge the low word is returned.
      if (rd && off == REG_MTIME_LO) shadow_d = mtime_hi_q;

      // Unwritten bytes keep the incremented value; a LO write drops the carry.
      if (wr) begin
         case (off)
            REG_MTIME_LO: begin
               mtime_lo_d = byte_merge(mtime_lo_d, wb.i_wb_dat, wb.i_wb_sel);
               mtime_hi_d = mtime_hi_q;
            end
            REG_MTIME_HI:    mtime_hi_d = byte_merge(mtime_hi_d, wb.i_wb_dat, wb.i_wb_sel);
            REG_MTIMECMP_LO: cmp_lo_d   = byte_merge(cmp_lo_q, wb.i_wb_dat, wb.i_wb_sel);
            REG_MTIMECMP_HI: cmp_hi_d   = byte_merge(cmp_hi_q, wb.i_wb_dat, wb.i_wb_sel);
            REG_CTRL: begin
               en_d = ctrl_new[CTRL_EN];
               ie_d = ctrl_new[CTRL_IE];
            end
            default: ;
         endcase
      end

      if (req) begin
         case (off)
            REG_MTIME_LO:    rdt_d = mtime_lo_q;
            REG_MTIME_HI:    rdt_d = shadow_q;
            REG_MTIMECMP_LO: rdt_d = cmp_lo_q;
            REG_MTIMECMP_HI: rdt_d = cmp_hi_q;
            REG_CTRL:        rdt_d = ctrl_word;
            REG_STATUS:      rdt_d = {31'd0, cmp_hit};
            default:         rdt_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ack_q      <= 1'b0;
         rdt_q      <= '0;
         mtime_lo_q <= '0;
         mtime_hi_q <= '0;
         cmp_lo_q   <= MTIMECMP_RST[31:0];
         cmp_hi_q   <= MTIMECMP_RST[63:32];
         shadow_q   <= '0;
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         presc_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         rdt_q      <= rdt_d;
         mtime_lo_q <= mtime_lo_d;
         mtime_hi_q <= mtime_hi_d;
         cmp_lo_q   <= cmp_lo_d;
         cmp_hi_q   <= cmp_hi_d;
         shadow_q   <= shadow_d;
         en_q       <= en_d;
         ie_q       <= ie_d;
         presc_q    <= presc_d;
         irq_q      <= irq_d;
      end
   end

   assign wb.o_wb_ack = ack_q;
   assign wb.o_wb_rdt = rdt_q;
   assign o_timer_irq = irq_q;

endmodule
